// File: rtl/controle_nivel.sv
// Tank level controller: synchronized, debounced level sensors drive an idle/fill/fault FSM
// that emits one-cycle open/close commands. Optional fill timeout enabled by ALARME_TIMEOUT_EN.
module controle_nivel #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic manual,
  input  logic sensor_baixo,
  input  logic sensor_alto,
  input  logic limpa_falha,
  output logic abre_auto,
  output logic fecha_auto,
  output logic enchendo,
  output logic falha
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENCHENDO = 2'd1,
    FALHA    = 2'd2
  } estado_t;

  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_CICLOS - 1);

  // Bit 0 carries sensor_baixo, bit 1 carries sensor_alto through the filter chain.
  logic [1:0]      sync_p0;
  logic [1:0]      sync_p1;
  logic [1:0]      filt;
  logic [1:0][7:0] deb_cnt;

  estado_t estado;
  logic    baixo_f;
  logic    alto_f;
  logic    incons;
  logic    tmo_fim;

  assign baixo_f = filt[0];
  assign alto_f  = filt[1];
  assign incons  = baixo_f & alto_f;

  // Synchronizer and debounce stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      filt    <= '0;
      deb_cnt <= '0;
    end else begin
      sync_p0 <= {sensor_alto, sensor_baixo};
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LIM) begin
          // The edge that would take the count to DEBOUNCE_CICLOS accepts the new value.
          filt[i]    <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

`ifdef ALARME_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Held at zero outside ENCHENDO, so it is already clear on the entry edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (estado != ENCHENDO) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_fim = (tmo_cnt == 16'(TIMEOUT_CICLOS - 1));
`else
  assign tmo_fim = 1'b0;
`endif

  // Control FSM stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= OCIOSO;
      abre_auto  <= 1'b0;
      fecha_auto <= 1'b0;
      enchendo   <= 1'b0;
      falha      <= 1'b0;
    end else begin
      abre_auto  <= 1'b0;
      fecha_auto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (incons) begin
            estado <= FALHA;
            falha  <= 1'b1;
          end else if (!manual && baixo_f) begin
            estado    <= ENCHENDO;
            enchendo  <= 1'b1;
            abre_auto <= 1'b1;
          end
        end
        ENCHENDO: begin
          if (manual || (!incons && alto_f)) begin
            estado     <= OCIOSO;
            enchendo   <= 1'b0;
            fecha_auto <= 1'b1;
          end else if (incons || tmo_fim) begin
            estado     <= FALHA;
            enchendo   <= 1'b0;
            falha      <= 1'b1;
            fecha_auto <= 1'b1;
          end
        end
        FALHA: begin
          if (limpa_falha && !incons) begin
            estado <= OCIOSO;
            falha  <= 1'b0;
          end
        end
        default: begin
          estado   <= OCIOSO;
          enchendo <= 1'b0;
          falha    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_nivel.sv
// Scoreboard bench for controle_nivel: expected output vectors {abre,fecha,enchendo,falha}
// are queued with their cycle stamp when stimulus is applied and compared on the falling edge.
module tb_controle_nivel;

  localparam int DEB = 4;
  localparam int TMO = 20;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic manual = 1'b0;
  logic sensor_baixo = 1'b0;
  logic sensor_alto = 1'b0;
  logic limpa_falha = 1'b0;
  logic abre_auto, fecha_auto, enchendo, falha;
  logic [3:0] outs;

  controle_nivel #(
    .DEBOUNCE_CICLOS(DEB),
    .TIMEOUT_CICLOS (TMO)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .manual      (manual),
    .sensor_baixo(sensor_baixo),
    .sensor_alto (sensor_alto),
    .limpa_falha (limpa_falha),
    .abre_auto   (abre_auto),
    .fecha_auto  (fecha_auto),
    .enchendo    (enchendo),
    .falha       (falha)
  );

  assign outs = {abre_auto, fecha_auto, enchendo, falha};

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic mark();
    t0 = cyc;
  endtask

  task automatic push(input int dc, input logic [3:0] v, input string tag);
    exp_t e;
    e.cyc = t0 + dc;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int dc);
    while (cyc < t0 + dc) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Outputs are observed half a cycle after each rising edge.
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) chk({e.tag, "_late"}, cyc, e.cyc);
      else chk(e.tag, outs, e.v);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    mark();
    push(0, 4'b0000, "rst_state");
    wait_to(1);
    reset_n = 1'b1;

    // Low sensor asserts: fill starts at edge 2+DEB+1
    mark();
    sensor_baixo = 1'b1;
    push(6, 4'b0000, "a_pre");
    push(7, 4'b1010, "a_abre");
    push(8, 4'b0010, "a_ench");
    wait_to(9);

    // High mark reached: close pulse and back to idle
    mark();
    sensor_baixo = 1'b0;
    sensor_alto  = 1'b1;
    push(6, 4'b0010, "b_pre");
    push(7, 4'b0100, "b_fecha");
    push(8, 4'b0000, "b_ocioso");
    wait_to(9);
    sensor_alto = 1'b0;
    wait_to(18);

    // Short glitch on the low sensor is rejected
    mark();
    sensor_baixo = 1'b1;
    push(5, 4'b0000, "c_glitch5");
    push(7, 4'b0000, "c_glitch7");
    push(10, 4'b0000, "c_glitch10");
    wait_to(3);
    sensor_baixo = 1'b0;
    wait_to(12);

    // Fill that never reaches the high mark
    mark();
    sensor_baixo = 1'b1;
    push(7, 4'b1010, "d_abre");
`ifdef ALARME_TIMEOUT_EN
    push(6 + TMO, 4'b0010, "d_pre_tmo");
    push(7 + TMO, 4'b0101, "d_tmo");
    push(8 + TMO, 4'b0001, "d_falha");
    wait_to(10 + TMO);
    mark();
    limpa_falha = 1'b1;
    push(1, 4'b0000, "d_limpa");
    push(2, 4'b1010, "d_reentra");
    push(3, 4'b0010, "d_reench");
    wait_to(1);
    limpa_falha = 1'b0;
    wait_to(3);
`else
    push(107, 4'b0010, "d_sem_tmo");
    wait_to(108);
`endif

    // Manual override closes and blocks re-entry
    mark();
    manual = 1'b1;
    push(1, 4'b0100, "m_fecha");
    push(2, 4'b0000, "m_ocioso");
    push(4, 4'b0000, "m_bloqueia");
    wait_to(5);
    mark();
    manual = 1'b0;
    push(1, 4'b1010, "m_reentra");
    push(2, 4'b0010, "m_reench");
    wait_to(3);

    // Reset mid-fill: outputs drop at once, no close pulse
    mark();
    reset_n = 1'b0;
    sensor_baixo = 1'b0;
    push(0, 4'b0000, "rst_imm");
    push(1, 4'b0000, "rst_hold");
    wait_to(2);
    reset_n = 1'b1;

    // Both sensors high while idle: fault without pulses
    mark();
    sensor_baixo = 1'b1;
    sensor_alto  = 1'b1;
    push(1, 4'b0000, "f_pos_rst");
    push(6, 4'b0000, "f_pre");
    push(7, 4'b0001, "f_falha");
    wait_to(9);
    mark();
    limpa_falha = 1'b1;
    push(1, 4'b0001, "f_limpa_ign1");
    push(2, 4'b0001, "f_limpa_ign2");
    wait_to(1);
    limpa_falha = 1'b0;
    wait_to(2);
    mark();
    sensor_alto = 1'b0;
    push(8, 4'b0001, "f_mantida");
    wait_to(9);
    mark();
    limpa_falha = 1'b1;
    push(1, 4'b0000, "f_limpa");
    push(2, 4'b1010, "f_reentra");
    wait_to(1);
    limpa_falha = 1'b0;
    wait_to(3);

    // Inconsistency during fill: fault with close pulse
    mark();
    sensor_alto = 1'b1;
    push(6, 4'b0010, "g_pre");
    push(7, 4'b0101, "g_incons");
    push(8, 4'b0001, "g_falha");
    wait_to(9);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clock);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
